// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared RAM status type for the memory subsystem
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - NREQ-way single-port RAM arbiter (IDLE/XFER, one access at a time)
// Define RAM_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NREQ-1:0]            req_ren,
  input  logic [NREQ-1:0]            req_wen,
  input  logic [NREQ-1:0][31:0]      req_addr,
  input  logic [NREQ-1:0][31:0]      req_store,
  input  ramstate_t                  ramstate,
  input  logic [31:0]                ramload,
  output logic [31:0]                ramaddr,
  output logic [31:0]                ramstore,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [NREQ-1:0]            req_wait,
  output logic [31:0]                req_load,
  output logic [NREQ-1:0]            grant,
  output logic                       err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   winner;
  logic [NREQ-1:0] req_any;
  logic            any_req;
  logic            owner_active;
  logic            done;
  logic            abort;

  assign req_any      = req_ren | req_wen;
  assign any_req      = |req_any;
  assign owner_active = (state == XFER) && req_any[owner];
  assign done         = owner_active && (ramstate == ACCESS);
  assign abort        = (state == XFER) && !req_any[owner];

`ifdef RAM_ARB_RR_EN
  // Walk candidates in reverse search order so the first hit after last_grant is kept.
  always_comb begin
    int k;
    k = 0;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(last_grant) + 1 + i;
      if (k >= NREQ) k = k - NREQ;
      if (req_any[IW'(k)]) winner = IW'(k);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_any[IW'(i)]) winner = IW'(i);
    end
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IW'(NREQ - 1);
      grant      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= XFER;
            owner <= winner;
            grant <= ONE << winner;
          end
        end
        XFER: begin
          if (abort) begin
            state <= IDLE;
            grant <= '0;
          end else if (done) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= owner;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Command and completion are combinational so ACCESS completes in the cycle it is seen.
  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    req_wait = '1;
    err      = 1'b0;
    if (state == XFER) begin
      ramaddr  = req_addr[owner];
      ramstore = req_store[owner];
      if (owner_active) begin
        ramWEN = req_wen[owner];
        ramREN = req_ren[owner] & ~req_wen[owner];
        err    = (ramstate == ERROR);
        if (ramstate == ACCESS) req_wait[owner] = 1'b0;
      end
    end
  end

  assign req_load = ramload;

  assert property (@(posedge CLK) disable iff (!nRST) $onehot0(grant));
  assert property (@(posedge CLK) disable iff (!nRST)
                   ({1'b0, last_grant} < (IW + 1)'(NREQ)));

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter (model compare + directed vectors)
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int N = 4;

  logic              CLK = 1'b0;
  logic              nRST = 1'b1;
  logic [N-1:0]      req_ren = '0;
  logic [N-1:0]      req_wen = '0;
  logic [N-1:0][31:0] req_addr = '0;
  logic [N-1:0][31:0] req_store = '0;
  ramstate_t         ramstate = FREE;
  logic [31:0]       ramload = '0;
  logic [31:0]       ramaddr, ramstore, req_load;
  logic              ramREN, ramWEN, err;
  logic [N-1:0]      req_wait, grant;

  int checks = 0;
  int errors = 0;

  // Model state: owner index (-1 when nobody holds the RAM) and last completed owner.
  int m_owner = -1;
  int m_last  = N - 1;

  logic [31:0]  e_addr, e_store;
  logic         e_ren, e_wen, e_err, m_act;
  logic [N-1:0] e_wait, e_grant;
  logic [N-1:0] exp_g [5];

  always #5 CLK = ~CLK;

  ram_arbiter #(.NREQ(N)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .ramstate(ramstate),
    .ramload(ramload), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN), .req_wait(req_wait),
    .req_load(req_load), .grant(grant), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    int k;
`ifdef RAM_ARB_RR_EN
    for (int i = 1; i <= N; i++) begin
      k = (last + i) % N;
      if (r[k]) return k;
    end
`else
    for (int i = 0; i < N; i++) begin
      k = i;
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner = -1;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      if (|(req_ren | req_wen)) m_owner = pick(req_ren | req_wen, m_last);
    end else if (!(req_ren[m_owner] | req_wen[m_owner])) begin
      m_owner = -1;
    end else if (ramstate == ACCESS) begin
      m_last  = m_owner;
      m_owner = -1;
    end
  end

  always @(negedge CLK) begin
    e_addr = '0; e_store = '0; e_ren = 1'b0; e_wen = 1'b0; e_err = 1'b0;
    e_wait = '1; e_grant = '0; m_act = 1'b0;
    if (m_owner >= 0) begin
      m_act   = req_ren[m_owner] | req_wen[m_owner];
      e_grant = N'(1) << m_owner;
      e_addr  = req_addr[m_owner];
      e_store = req_store[m_owner];
      if (m_act) begin
        e_wen = req_wen[m_owner];
        e_ren = req_ren[m_owner] & ~req_wen[m_owner];
        e_err = (ramstate == ERROR);
        if (ramstate == ACCESS) e_wait[m_owner] = 1'b0;
      end
    end
    check("cmp_grant", grant, e_grant);
    check("cmp_ramREN", ramREN, e_ren);
    check("cmp_ramWEN", ramWEN, e_wen);
    check("cmp_ramaddr", ramaddr, e_addr);
    check("cmp_ramstore", ramstore, e_store);
    check("cmp_req_wait", req_wait, e_wait);
    check("cmp_req_load", req_load, ramload);
    check("cmp_err", err, e_err);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
    ramload = $urandom;
  endtask

  initial begin
`ifdef RAM_ARB_RR_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001;
    exp_g[3] = 4'b0001; exp_g[4] = 4'b0001;
`endif
    #1 nRST = 1'b0;
    tick(); tick();
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_wait", req_wait, 4'b1111);
    check("rst_ren", ramREN, 1'b0);
    check("rst_wen", ramWEN, 1'b0);
    check("rst_addr", ramaddr, 32'h0);
    check("rst_err", err, 1'b0);

    // Single read by requester 2, BUSY twice then ACCESS
    nRST = 1'b1;
    req_ren = 4'b0100; req_addr[2] = 32'h40; ramstate = BUSY;
    #1 check("t1_idle_grant", grant, 4'b0000);
    check("t1_idle_ren", ramREN, 1'b0);
    tick();
    #1 check("t1_grant", grant, 4'b0100);
    check("t1_ren", ramREN, 1'b1);
    check("t1_addr", ramaddr, 32'h40);
    check("t1_wait_busy1", req_wait, 4'b1111);
    tick();
    #1 check("t1_wait_busy2", req_wait, 4'b1111);
    tick();
    ramstate = ACCESS;
    #1 check("t1_wait_done", req_wait, 4'b1011);
    tick();
    req_ren = '0; ramstate = FREE;
    #1 check("t1_back_idle", grant, 4'b0000);
    tick();

    // Write by 0 and read by 1 together
    req_wen = 4'b0001; req_addr[0] = 32'h100; req_store[0] = 32'hAAAA;
    req_ren = 4'b0010; req_addr[1] = 32'h200; ramstate = ACCESS;
    #1 check("t2_idle_grant", grant, 4'b0000);
    tick();
    #1 check("t2_grant0", grant, 4'b0001);
    check("t2_wen", ramWEN, 1'b1);
    check("t2_ren_low", ramREN, 1'b0);
    check("t2_store", ramstore, 32'hAAAA);
    check("t2_wait0", req_wait, 4'b1110);
    tick();
    req_wen = '0;
    #1 check("t2_gap", grant, 4'b0000);
    check("t2_gap_ren", ramREN, 1'b0);
    tick();
    #1 check("t2_grant1", grant, 4'b0010);
    check("t2_ren", ramREN, 1'b1);
    check("t2_addr1", ramaddr, 32'h200);
    check("t2_wait1", req_wait, 4'b1101);
    tick();
    req_ren = '0;
    tick();

    // All four requesting continuously from a fresh reset
    nRST = 1'b0;
    tick();
    nRST = 1'b1; req_ren = 4'hF; ramstate = ACCESS;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c % 2 == 1) check("t3_order", grant, exp_g[c / 2]);
      else check("t3_gap", grant, 4'b0000);
      tick();
    end
    req_ren = '0; ramstate = FREE;
    tick();

    // Owner 1 aborts; pointer must remain at its reset value
    nRST = 1'b0;
    tick();
    nRST = 1'b1; req_ren = 4'b0010; req_addr[1] = 32'h300; ramstate = BUSY;
    tick();
    #1 check("t4_grant", grant, 4'b0010);
    check("t4_ren", ramREN, 1'b1);
    tick();
    req_ren = '0;
    #1 check("t4_abort_ren", ramREN, 1'b0);
    check("t4_abort_wen", ramWEN, 1'b0);
    tick();
    req_ren = 4'b0110;
    #1 check("t4_idle", grant, 4'b0000);
    tick();
    ramstate = ACCESS;
    #1 check("t4_regrant", grant, 4'b0010);
    tick();
    req_ren = '0; ramstate = FREE;
    tick();

    // ERROR for three cycles, then ACCESS
    req_wen = 4'b1000; req_addr[3] = 32'h500; req_store[3] = 32'h55;
    tick();
    ramstate = ERROR;
    for (int c = 0; c < 3; c++) begin
      #1 check("t5_err", err, 1'b1);
      check("t5_wait", req_wait, 4'b1111);
      check("t5_wen", ramWEN, 1'b1);
      tick();
    end
    ramstate = ACCESS;
    #1 check("t5_err_clear", err, 1'b0);
    check("t5_done", req_wait, 4'b0111);
    tick();
    req_wen = '0; ramstate = FREE;
    #1 check("t5_idle", grant, 4'b0000);
    tick();

    // Reset in the middle of a transfer
    req_ren = 4'b0001; req_addr[0] = 32'h600; ramstate = BUSY;
    tick();
    #1 check("t6_grant", grant, 4'b0001);
    check("t6_ren", ramREN, 1'b1);
    nRST = 1'b0;
    #1 check("t6_rst_grant", grant, 4'b0000);
    check("t6_rst_ren", ramREN, 1'b0);
    check("t6_rst_wen", ramWEN, 1'b0);
    check("t6_rst_wait", req_wait, 4'b1111);
    tick();
    req_ren = '0;
    tick();
    nRST = 1'b1; req_ren = 4'b1001;
    #1 check("t6_post_idle", grant, 4'b0000);
    tick();
    #1 check("t6_post_grant", grant, 4'b0001);
    ramstate = ACCESS;
    tick();
    req_ren = '0; ramstate = FREE;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
